// File: rtl/uart_tx_pkg.sv
// Shared types and widths for the UART transmit scheduler slice.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_BAUD_W  = 12;
  localparam int unsigned UART_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } tx_sched_state_e;

endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// Combinational two-way grant; round-robin when UART_TX_SCHED_RR_EN is defined,
// otherwise fixed priority with requester 0 highest.
module uart_tx_rr_arbiter
  import uart_tx_pkg::*;
(
  input  logic [UART_NUM_REQ-1:0] valid,
  input  logic                    last_grant,
  output logic                    grant_valid,
  output logic                    grant
);

`ifdef UART_TX_SCHED_RR_EN
  always_comb begin
    grant_valid = |valid;
    if (&valid) grant = ~last_grant;
    else        grant = valid[1] & ~valid[0];
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = |valid;
    grant       = valid[1] & ~valid[0];
  end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte requesters and sequences one UART frame at a time.
// Arbitration mode selected by macro UART_TX_SCHED_RR_EN (see uart_tx_rr_arbiter).
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [UART_DATA_W-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [UART_DATA_W-1:0] req1_data,
  output logic                   req1_ready,
  input  logic [UART_BAUD_W-1:0] cfg_baud_divisor,
  input  logic                   cfg_parity_sel,
  input  logic                   cfg_two_stop_bits,
  output logic [UART_DATA_W-1:0] dp_data,
  output logic [UART_BAUD_W-1:0] dp_baud_divisor,
  output logic                   dp_parity_sel,
  output logic                   dp_two_stop_bits,
  output logic                   dp_tx_start,
  output logic                   dp_tx_sel,
  input  logic                   dp_tx_done,
  output logic                   busy,
  output logic                   grant_id,
  output logic                   frame_done
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  tx_sched_state_e state;
  logic            last_grant;
  logic            arb_valid;
  logic            arb_grant;
  logic            accept;
  logic [7:0]      gap_cnt;

  uart_tx_rr_arbiter u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // Reset gates the handshake and the completion pulse so neither leaks out
  // in the cycle the FSM is being forced back to IDLE.
  always_comb begin
    accept     = (state == IDLE) && !reset && arb_valid;
    req0_ready = accept && !arb_grant;
    req1_ready = accept && arb_grant;
    frame_done = (state == SEND) && dp_tx_done && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      dp_tx_start      <= 1'b0;
      dp_tx_sel        <= 1'b0;
      dp_data          <= '0;
      dp_baud_divisor  <= '0;
      dp_parity_sel    <= 1'b0;
      dp_two_stop_bits <= 1'b0;
      grant_id         <= 1'b0;
      last_grant       <= 1'b1;
      gap_cnt          <= '0;
    end else begin
      dp_tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            dp_data          <= arb_grant ? req1_data : req0_data;
            dp_baud_divisor  <= cfg_baud_divisor;
            dp_parity_sel    <= cfg_parity_sel;
            dp_two_stop_bits <= cfg_two_stop_bits;
            grant_id         <= arb_grant;
            last_grant       <= arb_grant;
            dp_tx_start      <= 1'b1;
            busy             <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          dp_tx_sel <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (dp_tx_done) begin
            dp_tx_sel <= 1'b0;
            gap_cnt   <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (no gap, 5-cycle gap) driven by
// a directed prelude then random traffic, checked against a frame-level model.
module tb_uart_tx_scheduler;

  localparam int unsigned GAP_A = 0;
  localparam int unsigned GAP_B = 5;
  localparam int          NCYC  = 3000;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        r0v   [2];
  logic        r1v   [2];
  logic [7:0]  r0d   [2];
  logic [7:0]  r1d   [2];
  logic [11:0] baud  [2];
  logic        par   [2];
  logic        two   [2];
  logic        done  [2];

  logic        r0rdy [2];
  logic        r1rdy [2];
  logic [7:0]  dpd   [2];
  logic [11:0] dpb   [2];
  logic        dpp   [2];
  logic        dp2   [2];
  logic        st    [2];
  logic        sel   [2];
  logic        bsy   [2];
  logic        gid   [2];
  logic        fd    [2];

  logic        n_rst  [2];
  logic        n_r0v  [2];
  logic        n_r1v  [2];
  logic [7:0]  n_r0d  [2];
  logic [7:0]  n_r1d  [2];
  logic [11:0] n_baud [2];
  logic        n_par  [2];
  logic        n_two  [2];
  logic        n_done [2];
  int          dcnt   [2];

  // Frame-level model: a frame is "active" from acceptance until its gap ends;
  // age counts cycles since acceptance (1 = the start-pulse cycle).
  bit          m_active [2];
  int          m_age    [2];
  bit          m_dseen  [2];
  int          m_gap    [2];
  logic        m_last   [2];
  logic        m_grant  [2];
  logic [7:0]  m_data   [2];
  logic [11:0] m_baud   [2];
  logic        m_par    [2];
  logic        m_two    [2];
  int          gapv     [2];

  uart_tx_scheduler #(.GAP_CYCLES(GAP_A)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .req0_valid(r0v[0]), .req0_data(r0d[0]), .req0_ready(r0rdy[0]),
    .req1_valid(r1v[0]), .req1_data(r1d[0]), .req1_ready(r1rdy[0]),
    .cfg_baud_divisor(baud[0]), .cfg_parity_sel(par[0]), .cfg_two_stop_bits(two[0]),
    .dp_data(dpd[0]), .dp_baud_divisor(dpb[0]), .dp_parity_sel(dpp[0]),
    .dp_two_stop_bits(dp2[0]), .dp_tx_start(st[0]), .dp_tx_sel(sel[0]),
    .dp_tx_done(done[0]), .busy(bsy[0]), .grant_id(gid[0]), .frame_done(fd[0])
  );

  uart_tx_scheduler #(.GAP_CYCLES(GAP_B)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .req0_valid(r0v[1]), .req0_data(r0d[1]), .req0_ready(r0rdy[1]),
    .req1_valid(r1v[1]), .req1_data(r1d[1]), .req1_ready(r1rdy[1]),
    .cfg_baud_divisor(baud[1]), .cfg_parity_sel(par[1]), .cfg_two_stop_bits(two[1]),
    .dp_data(dpd[1]), .dp_baud_divisor(dpb[1]), .dp_parity_sel(dpp[1]),
    .dp_two_stop_bits(dp2[1]), .dp_tx_start(st[1]), .dp_tx_sel(sel[1]),
    .dp_tx_done(done[1]), .busy(bsy[1]), .grant_id(gid[1]), .frame_done(fd[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  function automatic int winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef UART_TX_SCHED_RR_EN
      return (last == 1'b1) ? 0 : 1;
`else
      return (last == 1'b1) ? 0 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset(input int i);
    m_active[i] = 0; m_age[i] = 0; m_dseen[i] = 0; m_gap[i] = 0;
    m_last[i] = 1'b1; m_grant[i] = 1'b0; m_data[i] = '0; m_baud[i] = '0;
    m_par[i] = 1'b0; m_two[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int   w;
    logic e_rdy0, e_rdy1, e_sel, e_st, e_fd;
    w      = winner(r0v[i], r1v[i], m_last[i]);
    e_rdy0 = !rst[i] && !m_active[i] && (w == 0);
    e_rdy1 = !rst[i] && !m_active[i] && (w == 1);
    e_st   = m_active[i] && (m_age[i] == 1);
    e_sel  = m_active[i] && (m_age[i] >= 2) && !m_dseen[i];
    e_fd   = e_sel && done[i] && !rst[i];
    chk("req0_ready", i, 32'(r0rdy[i]), 32'(e_rdy0));
    chk("req1_ready", i, 32'(r1rdy[i]), 32'(e_rdy1));
    chk("busy",       i, 32'(bsy[i]),   32'(m_active[i]));
    chk("tx_start",   i, 32'(st[i]),    32'(e_st));
    chk("tx_sel",     i, 32'(sel[i]),   32'(e_sel));
    chk("frame_done", i, 32'(fd[i]),    32'(e_fd));
    chk("grant_id",   i, 32'(gid[i]),   32'(m_grant[i]));
    chk("dp_data",    i, 32'(dpd[i]),   32'(m_data[i]));
    chk("dp_baud",    i, 32'(dpb[i]),   32'(m_baud[i]));
    chk("dp_parity",  i, 32'(dpp[i]),   32'(m_par[i]));
    chk("dp_two_stop",i, 32'(dp2[i]),   32'(m_two[i]));

    if (rst[i]) begin
      model_reset(i);
    end else if (!m_active[i]) begin
      if (w >= 0) begin
        m_grant[i]  = (w == 1);
        m_last[i]   = (w == 1);
        m_data[i]   = (w == 1) ? r1d[i] : r0d[i];
        m_baud[i]   = baud[i];
        m_par[i]    = par[i];
        m_two[i]    = two[i];
        m_active[i] = 1;
        m_age[i]    = 1;
        m_dseen[i]  = 0;
      end
    end else if (!m_dseen[i]) begin
      if (e_fd) begin
        m_dseen[i] = 1;
        m_gap[i]   = gapv[i];
        if (gapv[i] == 0) m_active[i] = 0;
      end else begin
        m_age[i]++;
      end
    end else begin
      m_gap[i]--;
      if (m_gap[i] == 0) m_active[i] = 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = n_rst[i]; r0v[i] = n_r0v[i]; r1v[i] = n_r1v[i];
      r0d[i] = n_r0d[i]; r1d[i] = n_r1d[i]; baud[i] = n_baud[i];
      par[i] = n_par[i]; two[i] = n_two[i]; done[i] = n_done[i];
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
  endtask

  task automatic drive_random(input int i);
    n_rst[i] = ($urandom_range(0, 199) == 0);
    if (r0v[i] && r0rdy[i]) begin
      n_r0v[i] = ($urandom_range(0, 3) != 0); n_r0d[i] = 8'($urandom);
    end else if (!r0v[i]) begin
      n_r0v[i] = ($urandom_range(0, 2) == 0); n_r0d[i] = 8'($urandom);
    end
    if (r1v[i] && r1rdy[i]) begin
      n_r1v[i] = ($urandom_range(0, 3) != 0); n_r1d[i] = 8'($urandom);
    end else if (!r1v[i]) begin
      n_r1v[i] = ($urandom_range(0, 2) == 0); n_r1d[i] = 8'($urandom);
    end
    if ($urandom_range(0, 3) == 0) begin
      n_baud[i] = 12'($urandom); n_par[i] = 1'($urandom); n_two[i] = 1'($urandom);
    end
    // Datapath stand-in: done stays high until the next start pulse clears it.
    if (st[i]) begin
      n_done[i] = 1'b0;
      dcnt[i]   = $urandom_range(1, 6);
    end else if (sel[i] && !done[i] && dcnt[i] > 0) begin
      dcnt[i]--;
      if (dcnt[i] == 0) n_done[i] = 1'b1;
    end
  endtask

  logic [7:0] exp_d2;
  logic       exp_g2;

  initial begin
    gapv[0] = GAP_A; gapv[1] = GAP_B;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      dcnt[i] = 0;
      rst[i] = 1'b1; r0v[i] = 1'b0; r1v[i] = 1'b0; r0d[i] = '0; r1d[i] = '0;
      baud[i] = '0; par[i] = 1'b0; two[i] = 1'b0; done[i] = 1'b0;
      n_rst[i] = 1'b1; n_r0v[i] = 1'b1; n_r0d[i] = 8'hA5; n_r1v[i] = 1'b1;
      n_r1d[i] = 8'h22; n_baud[i] = 12'h010; n_par[i] = 1'b0; n_two[i] = 1'b0;
      n_done[i] = 1'b1;
    end
`ifdef UART_TX_SCHED_RR_EN
    exp_d2 = 8'h22; exp_g2 = 1'b1;
`else
    exp_d2 = 8'h11; exp_g2 = 1'b0;
`endif

    advance();                       // reset with valid high
    chk("lit_rst_busy",   0, 32'(bsy[0]),   32'd0);
    chk("lit_rst_ready0", 0, 32'(r0rdy[0]), 32'd0);
    chk("lit_rst_data",   0, 32'(dpd[0]),   32'd0);
    chk("lit_rst_sel",    0, 32'(sel[0]),   32'd0);

    for (int i = 0; i < 2; i++) n_rst[i] = 1'b0;
    advance();                       // idle, both valid: requester 0 first
    chk("lit_first_ready0", 0, 32'(r0rdy[0]), 32'd1);
    chk("lit_first_ready1", 0, 32'(r1rdy[0]), 32'd0);

    for (int i = 0; i < 2; i++) n_r0v[i] = 1'b0;
    advance();                       // LOAD with stale done still high
    chk("lit_load_start", 0, 32'(st[0]),  32'd1);
    chk("lit_load_sel",   0, 32'(sel[0]), 32'd0);
    chk("lit_load_data",  0, 32'(dpd[0]), 32'hA5);
    chk("lit_load_baud",  0, 32'(dpb[0]), 32'h010);

    for (int i = 0; i < 2; i++) begin
      n_done[i] = 1'b0; n_baud[i] = 12'h020; n_par[i] = 1'b1;
    end
    advance();                       // SEND, cfg changed after acceptance
    chk("lit_send_sel",    0, 32'(sel[0]), 32'd1);
    chk("lit_send_baud",   0, 32'(dpb[0]), 32'h010);
    chk("lit_send_parity", 0, 32'(dpp[0]), 32'd0);
    chk("lit_send_fd",     0, 32'(fd[0]),  32'd0);
    advance();
    advance();
    chk("lit_send_hold", 0, 32'(sel[0]), 32'd1);

    for (int i = 0; i < 2; i++) n_done[i] = 1'b1;
    advance();
    chk("lit_frame_done", 0, 32'(fd[0]),  32'd1);
    chk("lit_grant0",     0, 32'(gid[0]), 32'd0);

    for (int i = 0; i < 2; i++) begin
      n_r0v[i] = 1'b1; n_r0d[i] = 8'h11;
    end
    advance();                       // inst0 idle again, inst1 in gap
    chk("lit_b2b_busy",  0, 32'(bsy[0]),   32'd0);
    chk("lit_b2b_rdy1",  0, 32'(r1rdy[0]), 32'(exp_g2));
    chk("lit_gap_busy",  1, 32'(bsy[1]),   32'd1);
    chk("lit_gap_sel",   1, 32'(sel[1]),   32'd0);
    chk("lit_gap_rdy0",  1, 32'(r0rdy[1]), 32'd0);

    if (exp_g2) n_r1v[0] = 1'b0; else n_r0v[0] = 1'b0;
    advance();
    chk("lit_second_data",  0, 32'(dpd[0]), 32'(exp_d2));
    chk("lit_second_grant", 0, 32'(gid[0]), 32'(exp_g2));
    chk("lit_second_baud",  0, 32'(dpb[0]), 32'h020);

    n_done[0] = 1'b0;
    advance();                       // SEND
    n_rst[0] = 1'b1;
    advance();                       // reset asserted mid-frame
    chk("lit_midrst_fd", 0, 32'(fd[0]), 32'd0);
    n_rst[0] = 1'b0;
    advance();
    chk("lit_midrst_busy", 0, 32'(bsy[0]), 32'd0);
    chk("lit_midrst_sel",  0, 32'(sel[0]), 32'd0);

    for (int c = 0; c < NCYC; c++) begin
      for (int i = 0; i < 2; i++) drive_random(i);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencing controller for the UART transmit datapath. Arbitrates byte requests from two independent requesters (round-robin or fixed priority) and latches the winning byte together with the frame configuration. It then pulses `tx_start`, enables `tx_sel` for the duration of the frame, waits for `tx_done`, and optionally inserts an idle gap before the next frame. It sits between the host-side producers and `Tx_Datapath`, and is the only block that drives the datapath's control inputs.

## Interface
- `GAP_CYCLES`, default 0: idle clock cycles inserted after each frame; 0 means no gap state. Legal range 0–255.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in 8: requester 0 byte.
- `req0_ready` out 1: requester 0 byte accepted this cycle when `valid`&&`ready`.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `cfg_baud_divisor` in 12: baud divisor; sampled at acceptance.
- `cfg_parity_sel` in 1: 1 = even parity, 0 = odd; sampled at acceptance.
- `cfg_two_stop_bits` in 1: sampled at acceptance.
- `dp_data` out 8: to datapath `data`.
- `dp_baud_divisor` out 12: to datapath `baud_divisor`.
- `dp_parity_sel` out 1: to datapath `parity_sel`.
- `dp_two_stop_bits` out 1: to datapath `two_stop_bits`.
- `dp_tx_start` out 1: to datapath `tx_start`; one-cycle pulse.
- `dp_tx_sel` out 1: to datapath `tx_sel`; 1 only while a frame is on the line.
- `dp_tx_done` in 1: from datapath `tx_done`; level signal.
- `busy` out 1: state ≠ IDLE.
- `grant_id` out 1: requester owning the current or most recent frame.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on acceptance.
  - LOAD → SEND unconditionally.
  - SEND → GAP when `dp_tx_done`=1 and `GAP_CYCLES`>0.
  - SEND → IDLE when `dp_tx_done`=1 and `GAP_CYCLES`=0.
  - GAP → IDLE when the gap counter reaches `GAP_CYCLES`-1.
- Arbitration happens in IDLE only. `reqN_ready` is combinational and is 1 only in IDLE, for the winner. At most one `ready` is high per cycle.
- On acceptance, latch the following registers, which are held constant until the next acceptance:
  - winner's data into `dp_data`
  - `cfg_*` into the `dp_*` configuration outputs
  - winner index into `grant_id`
  - winner index into `last_grant`
- Changes to `cfg_*` after acceptance have no effect on the frame in flight.
- LOAD drives `dp_tx_start`=1 and `dp_tx_sel`=0, so the line stays idle-high while the shift register loads.
- SEND drives `dp_tx_sel`=1. `dp_tx_done` is sampled only in SEND; a stale high `tx_done` from the previous frame is cleared by the datapath at the LOAD edge and is never observed.
- `frame_done` pulses in the cycle SEND exits.
- GAP drives `dp_tx_sel`=0 (line high). An 8-bit counter is cleared on GAP entry and increments each cycle.
- Requests arriving while `busy` are held off (`ready`=0). Each requester must keep `valid` and `data` stable until accepted.

## Timing
- Reset values:
  - state IDLE, `busy`=0
  - `dp_tx_start`=0, `dp_tx_sel`=0, `frame_done`=0
  - `dp_data`=0, `dp_baud_divisor`=0, `dp_parity_sel`=0, `dp_two_stop_bits`=0
  - `grant_id`=0, `last_grant`=1, gap counter 0
- Accept at edge E → LOAD in cycle E+1 (`tx_start` high) → SEND from E+2.
- Back-to-back throughput: with `GAP_CYCLES`=0, the next acceptance can occur in the cycle after `frame_done`.
- Reset mid-frame (any state): return to IDLE next edge. `dp_tx_sel` drops to 0 immediately, so the line goes high and the partial frame is abandoned. No `frame_done` pulse; the byte is lost.
- `reset` and `valid` asserted in the same cycle: reset wins, `ready`=0.

## Configuration
- Macro `UART_TX_SCHED_RR_EN`.
- Defined: round-robin. When both requesters are valid, grant the requester ≠ `last_grant`; a single valid requester always wins.
- Undefined: fixed priority, requester 0 always wins. `last_grant` is still updated but unused for arbitration.

## Structure
- Package `uart_tx_pkg`:
  - state enum `tx_sched_state_e` {IDLE, LOAD, SEND, GAP}
  - constants `UART_DATA_W`=8, `UART_BAUD_W`=12, `UART_NUM_REQ`=2
- Sub-module `uart_tx_rr_arbiter`: combinational grant from `valid[1:0]` and `last_grant`; the `UART_TX_SCHED_RR_EN` selection lives there. The FSM, latches and gap counter stay in the top module.

## Test plan
- Single request: `req0_valid` with 0xA5, `GAP_CYCLES`=0.
  - `req0_ready` high one cycle.
  - `dp_tx_start` pulses the next cycle.
  - `dp_tx_sel`=1 until `dp_tx_done`.
  - `frame_done` fires once and `grant_id`=0.
- Contention, RR enabled: both valid continuously (0x11 / 0x22) → grants alternate 0,1,0,1 over 4 frames. Macro undefined: 0,0,0,0.
- Config latch: change `cfg_parity_sel` 0→1 and `cfg_baud_divisor` 0x010→0x020 during SEND → `dp_*` unchanged until the next acceptance.
- Gap: `GAP_CYCLES`=5 with back-to-back requests → exactly 5 cycles of `dp_tx_sel`=0 and `busy`=1 between `frame_done` and the next `ready`.
- Stale done: `dp_tx_done` held 1 from the prior frame into LOAD → SEND does not exit until a fresh `tx_done` rise; no spurious `frame_done`.
- Reset mid-SEND: assert `reset` halfway through a frame.
  - Next cycle: `busy`=0, `dp_tx_sel`=0, no `frame_done`.
  - A new `req1` is then accepted normally.
